// File: rtl/i2c_write_arbiter.sv
// Two-requester round-robin front end for a single I2C master: grants one register write at a time,
// launches it with a one-cycle start pulse, and returns a per-requester ack with a timeout flag.
module i2c_write_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_req,
  input  logic [6:0] r0_addr,
  input  logic [7:0] r0_sub,
  input  logic [7:0] r0_data,
  input  logic       r1_req,
  input  logic [6:0] r1_addr,
  input  logic [7:0] r1_sub,
  input  logic [7:0] r1_data,
  output logic       r0_ack,
  output logic       r0_err,
  output logic       r1_ack,
  output logic       r1_err,
  output logic [6:0] m_addr,
  output logic [7:0] m_sub,
  output logic [7:0] m_data,
  output logic       m_start,
  input  logic       m_ready,
  output logic       busy,
  output logic       owner
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] sub;
    logic [7:0] data;
  } wr_req_t;

  logic [2:0]        state;
  logic [15:0]       timer;
  logic              last_owner;
  logic              err_q;
  logic [1:0]        req_vec;
  logic              grant_id;
  wr_req_t [1:0]     ops;
  wr_req_t           m_q;

  assign req_vec = {r1_req, r0_req};
  assign ops[0]  = {r0_addr, r0_sub, r0_data};
  assign ops[1]  = {r1_addr, r1_sub, r1_data};

  // On a tie the requester that was not served last wins; a lone requester always wins.
  assign grant_id = (req_vec == 2'b11) ? ~last_owner : req_vec[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      m_q        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m_ready && (|req_vec)) begin
            state <= START;
            owner <= grant_id;
            m_q   <= ops[grant_id];
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!m_ready) begin
            state <= WAIT_DONE;
            timer <= '0;
          end else if (timer == TMO) begin
            state <= ACK;
            err_q <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (m_ready) begin
            state <= ACK;
            err_q <= 1'b0;
          end else if (timer == TMO) begin
            state <= ACK;
            err_q <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ACK: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses decode straight from the state register so they last exactly one state-cycle.
  assign m_start = (state == START);
  assign busy    = (state != IDLE);
  assign r0_ack  = (state == ACK) && !owner;
  assign r1_ack  = (state == ACK) &&  owner;
  assign r0_err  = r0_ack && err_q;
  assign r1_err  = r1_ack && err_q;
  assign m_addr  = m_q.addr;
  assign m_sub   = m_q.sub;
  assign m_data  = m_q.data;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Randomised + directed bench for i2c_write_arbiter against a transaction-window reference model.
module tb_i2c_write_arbiter;
  localparam int TO = 8;
  localparam int MM_HIGH = 0, MM_LOW = 1, MM_AUTO = 2, MM_HANG = 3, MM_RAND = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r0_req = 1'b0, r1_req = 1'b0;
  logic [6:0] r0_addr = '0, r1_addr = '0;
  logic [7:0] r0_sub = '0, r1_sub = '0, r0_data = '0, r1_data = '0;
  logic       m_ready = 1'b1;

  logic       r0_ack, r0_err, r1_ack, r1_err, m_start, busy, owner;
  logic [6:0] m_addr;
  logic [7:0] m_sub, m_data;
  logic       d_r0_ack, d_r0_err, d_r1_ack, d_r1_err, d_m_start, d_busy, d_owner;
  logic [6:0] d_m_addr;
  logic [7:0] d_m_sub, d_m_data;

  int n_chk = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;

  i2c_write_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_sub(r0_sub), .r0_data(r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_sub(r1_sub), .r1_data(r1_data),
    .r0_ack(r0_ack), .r0_err(r0_err), .r1_ack(r1_ack), .r1_err(r1_err),
    .m_addr(m_addr), .m_sub(m_sub), .m_data(m_data), .m_start(m_start),
    .m_ready(m_ready), .busy(busy), .owner(owner));

  // Default-TIMEOUT instance, used for the long single-write scenario.
  i2c_write_arbiter dut_d (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_sub(r0_sub), .r0_data(r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_sub(r1_sub), .r1_data(r1_data),
    .r0_ack(d_r0_ack), .r0_err(d_r0_err), .r1_ack(d_r1_ack), .r1_err(d_r1_err),
    .m_addr(d_m_addr), .m_sub(d_m_sub), .m_data(d_m_data), .m_start(d_m_start),
    .m_ready(m_ready), .busy(d_busy), .owner(d_owner));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a transfer is described by its start cycle s, the cycle e the master
  // was first seen busy, and the ack cycle. Windows: busy must appear at one of the edges
  // s+2..s+2+TO, then ready must return within e+1..e+1+TO; otherwise ack with err.
  bit         mo_active = 0, mo_owner = 0, mo_last = 1, mo_err = 0;
  int         mo_s = 0, mo_e = -1, mo_ack = -1;
  logic [6:0] mo_addr = '0;
  logic [7:0] mo_sub = '0, mo_data = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mo_active = 0; mo_owner = 0; mo_last = 1; mo_ack = -1; mo_e = -1;
      mo_addr = '0; mo_sub = '0; mo_data = '0;
    end else if (mo_active && mo_ack >= 0 && cyc == mo_ack + 1) begin
      mo_active = 0;
      mo_last   = mo_owner;
    end else if (!mo_active) begin
      if (m_ready && (r0_req || r1_req)) begin
        mo_owner = (r0_req && r1_req) ? !mo_last : r1_req;
        if (mo_owner) {mo_addr, mo_sub, mo_data} = {r1_addr, r1_sub, r1_data};
        else          {mo_addr, mo_sub, mo_data} = {r0_addr, r0_sub, r0_data};
        mo_active = 1; mo_s = cyc; mo_e = -1; mo_ack = -1;
      end
    end else if (mo_ack < 0 && cyc >= mo_s + 2) begin
      if (mo_e < 0) begin
        if (!m_ready) mo_e = cyc;
        else if (cyc == mo_s + 2 + TO) begin mo_ack = cyc; mo_err = 1; end
      end else if (m_ready) begin
        mo_ack = cyc; mo_err = 0;
      end else if (cyc == mo_e + 1 + TO) begin
        mo_ack = cyc; mo_err = 1;
      end
    end
  end

  logic ea0, ea1;
  always @(negedge clk) begin
    if (cyc > 0) begin
      ea0 = mo_active && (mo_ack == cyc) && !mo_owner;
      ea1 = mo_active && (mo_ack == cyc) &&  mo_owner;
      check("busy",    busy,    mo_active);
      check("m_start", m_start, mo_active && (cyc == mo_s));
      check("r0_ack",  r0_ack,  ea0);
      check("r1_ack",  r1_ack,  ea1);
      check("r0_err",  r0_err,  ea0 && mo_err);
      check("r1_err",  r1_err,  ea1 && mo_err);
      check("owner",   owner,   mo_owner);
      check("m_addr",  m_addr,  mo_addr);
      check("m_sub",   m_sub,   mo_sub);
      check("m_data",  m_data,  mo_data);
    end
  end

  // I2C master stand-in: after each start, stays ready for dly cycles then busy for hold cycles.
  int mmode = MM_HIGH, cfg_dly = 1, cfg_hold = 3, m_dly = 0, m_hold = 0;
  bit m_run = 0;
  always @(negedge clk) begin
    if (mmode == MM_HIGH) begin m_ready = 1'b1; m_run = 0; end
    else if (mmode == MM_LOW) begin m_ready = 1'b0; m_run = 0; end
    else begin
      if (m_start) begin
        if (mmode == MM_RAND) begin m_dly = $urandom_range(0, 12); m_hold = $urandom_range(1, 14); end
        else begin m_dly = cfg_dly; m_hold = cfg_hold; end
        m_run = 1;
      end
      if (m_run) begin
        if (m_dly > 0) begin m_dly--; m_ready = 1'b1; end
        else if (m_hold > 0 || mmode == MM_HANG) begin m_ready = 1'b0; if (m_hold > 0) m_hold--; end
        else begin m_ready = 1'b1; m_run = 0; end
      end else begin
        m_ready = (mmode == MM_RAND) ? ($urandom_range(0, 9) != 0) : 1'b1;
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0: return m_start;
      1: return r0_ack;
      2: return r1_ack;
      3: return r0_ack | r1_ack;
      4: return d_m_start;
      default: return busy;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sig(input int w, input string nm, output int t);
    t = -1;
    for (int k = 0; k < 300 && t < 0; k++) begin
      @(negedge clk);
      if (sig(w)) t = cyc;
    end
    if (t < 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: event never seen, got none, required one within 300 cycles", nm);
    end
  endtask

  task automatic do_reset();
    r0_req = 0; r1_req = 0; reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic rand_req(input logic ack, inout logic req, inout logic [6:0] a,
                          inout logic [7:0] s, inout logic [7:0] d);
    if (ack) req = ($urandom_range(0, 1) == 1);
    else if (!req) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b1; a = 7'($urandom); s = 8'($urandom); d = 8'($urandom);
      end
    end else if ($urandom_range(0, 39) == 0) req = 1'b0;
    else if ($urandom_range(0, 7) == 0) begin
      a = 7'($urandom); s = 8'($urandom); d = 8'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  int ts, ta, tg, nst, nack1;
  logic [3:0] ord;
  initial begin
    ord = 4'b1010;
    reset = 1'b1; mmode = MM_HIGH;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_mstart", m_start, 0);
    reset = 1'b0;

    // Single write on the default-timeout instance.
    mmode = MM_AUTO; cfg_dly = 2; cfg_hold = 40;
    r0_addr = 7'h68; r0_sub = 8'h20; r0_data = 8'h0F; r0_req = 1'b1;
    wait_sig(4, "d_start", ts);
    check("d_maddr", d_m_addr, 7'h68);
    check("d_msub", d_m_sub, 8'h20);
    check("d_mdata", d_m_data, 8'h0F);
    r0_addr = 7'h11; r0_sub = 8'h22; r0_data = 8'h33;
    nst = 1; nack1 = 0; ta = -1;
    for (int k = 0; k < 100 && ta < 0; k++) begin
      @(negedge clk);
      if (d_m_start) nst++;
      if (d_r1_ack || d_r1_err) nack1++;
      if (d_r0_ack) begin
        ta = cyc;
        check("d_err", d_r0_err, 0);
        check("d_owner", d_owner, 0);
        check("d_hold_addr", d_m_addr, 7'h68);
        check("d_hold_data", d_m_data, 8'h0F);
      end
    end
    check("d_latency", ta - ts, 43);
    check("d_starts", nst, 1);
    check("d_r1_ack", nack1, 0);
    r0_req = 1'b0;
    tick(1);
    check("d_busy_after", d_busy, 0);
    do_reset();

    // Tie after reset: alternate r0, r1, r0, r1.
    mmode = MM_AUTO; cfg_dly = 1; cfg_hold = 3;
    r0_addr = 7'h10; r1_addr = 7'h20; r0_req = 1'b1; r1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sig(3, "rr_ack", ta);
      check("rr_order", r1_ack, ord[i]);
      check("rr_owner", owner, ord[i]);
    end
    r0_req = 0; r1_req = 0;
    tick(3);

    // Start never accepted.
    do_reset();
    mmode = MM_HIGH; r0_req = 1'b1;
    wait_sig(0, "to_start", ts);
    wait_sig(1, "to_ack", ta);
    check("to_latency", ta - ts, 10);
    check("to_model_lat", mo_ack - mo_s, 10);
    check("to_err", r0_err, 1);
    r0_req = 1'b0;
    tick(1);
    check("to_busy", busy, 0);

    // Master hang, then a normal transfer.
    mmode = MM_HANG; cfg_dly = 0; r1_req = 1'b1;
    wait_sig(0, "hang_start", ts);
    wait_sig(2, "hang_ack", ta);
    check("hang_latency", ta - ts, 11);
    check("hang_err", r1_err, 1);
    r1_req = 1'b0; mmode = MM_AUTO; cfg_dly = 1; cfg_hold = 2; r0_req = 1'b1;
    wait_sig(1, "after_hang_ack", ta);
    check("after_hang_err", r0_err, 0);
    r0_req = 1'b0;
    tick(2);

    // Reset during WAIT_DONE.
    do_reset();
    mmode = MM_AUTO; cfg_dly = 0; cfg_hold = 20; r0_req = 1'b1; r0_addr = 7'h55;
    wait_sig(0, "rm_start", ts);
    tick(4);
    check("rm_busy_before", busy, 1);
    reset = 1'b1; r0_req = 1'b0;
    tick(1);
    reset = 1'b0;
    check("rm_busy", busy, 0);
    check("rm_ack", r0_ack | r1_ack, 0);
    check("rm_mstart", m_start, 0);
    check("rm_mops", {m_addr, m_sub, m_data}, 0);
    tick(3);
    check("rm_no_late_ack", r0_ack | r1_ack, 0);
    cfg_hold = 2; r0_req = 1'b1; r1_req = 1'b1;
    wait_sig(3, "rm_tie_ack", ta);
    check("rm_tie_r0", r0_ack, 1);
    r0_req = 0; r1_req = 0;
    tick(20);

    // Master not idle while r1 waits.
    do_reset();
    mmode = MM_LOW; tick(2);
    r1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("ni_no_start", m_start, 0);
    end
    mmode = MM_AUTO; cfg_dly = 1; cfg_hold = 2;
    wait_sig(5, "ni_grant", tg);
    check("ni_start_with_grant", m_start, 1);
    check("ni_owner", owner, 1);
    tick(1);
    check("ni_start_once", m_start, 0);
    wait_sig(2, "ni_ack", ta);
    r1_req = 1'b0;
    tick(2);

    // Randomised traffic with occasional resets.
    mmode = MM_RAND;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      rand_req(r0_ack, r0_req, r0_addr, r0_sub, r0_data);
      rand_req(r1_ack, r1_req, r1_addr, r1_sub, r1_data);
    end
    reset = 1'b0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_write_arbiter.md
I2C_WRITE_ARBITER -- requirements
Module: i2c_write_arbiter

Interface
REQ-001 The block SHALL have one parameter TIMEOUT, default 1023, giving the cycle limit for each wait state; legal range 2..65535.
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Ports r0_req / r1_req  input  1  requester 0/1 wants one register write; held high until its ack.
REQ-006 Ports r0_addr / r1_addr  input  7  requester 7-bit slave address.
REQ-007 Ports r0_sub / r1_sub  input  8  requester sub-register address.
REQ-008 Ports r0_data / r1_data  input  8  requester write data.
REQ-009 Ports r0_ack / r1_ack  output  1  one-cycle completion pulse to requester 0/1.
REQ-010 Ports r0_err / r1_err  output  1  valid only while the matching ack is high; 1 = timeout.
REQ-011 Ports m_addr / m_sub / m_data  output  7/8/8  registered operands to the I2C master.
REQ-012 Port m_start  output  1  one-cycle start pulse to the I2C master.
REQ-013 Port m_ready  input  1  I2C master idle flag; low while a transfer is in progress.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port owner  output  1  index of the requester currently served (or last served).

Function
REQ-016 The block SHALL implement the states IDLE, START, WAIT_BUSY, WAIT_DONE and ACK.
REQ-017 IDLE: when m_ready=1 and any req=1, grant one requester, latch its addr/sub/data into m_*, set owner, then go to START; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not in last_owner wins.
REQ-019 In IDLE with m_ready=0, no grant SHALL be made, even if requests are pending.
REQ-020 START: m_start=1 for exactly this one cycle, clear the timer, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY: if m_ready=0, go to WAIT_DONE and clear the timer; else if timer==TIMEOUT, go to ACK with err=1; else increment the timer.
REQ-022 WAIT_DONE: if m_ready=1, go to ACK with err=0; else if timer==TIMEOUT, go to ACK with err=1; else increment the timer.
REQ-023 ACK: pulse the owner's ack for one cycle with err valid, update last_owner to owner, then go to IDLE; the other ack SHALL stay 0.
REQ-024 The timer SHALL be 16 bits wide and SHALL never wrap, because it is compared against TIMEOUT before incrementing.
REQ-025 m_addr, m_sub and m_data SHALL hold their latched values from grant until the next grant; requester input changes after grant SHALL be ignored.
REQ-026 A req still high in the cycle after its ack SHALL be treated as a new request, subject to round-robin.
REQ-027 A req dropped before its ack SHALL NOT abort the transfer; the ack is still issued.
REQ-028 Grant-to-start latency SHALL be 1 cycle; m_ready rise to ack SHALL be 1 cycle.
REQ-029 At most one transfer SHALL be outstanding at any time.

Reset
REQ-030 While reset=1 at a clock edge: state=IDLE, timer=0, m_start=0, r0_ack=r1_ack=0, r0_err=r1_err=0, m_addr=0, m_sub=0, m_data=0, busy=0, owner=0, last_owner=1 (so r0 wins the first tie).
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no ack issued; the requester must re-request.
REQ-032 Reset SHALL take priority over every state transition in the same cycle.

Verification
REQ-033 Single write: r0_req=1, addr=0x68, sub=0x20, data=0x0F, master model drops m_ready 2 cycles after start and holds it low for 40 cycles -> exactly one m_start, m_*=0x68/0x20/0x0F, r0_ack pulse with r0_err=0, r1_ack=0.
REQ-034 Tie after reset: r0_req and r1_req both high, then both re-requesting -> grant order r0, r1, r0, r1 across four transfers; each owner value matches the ack issued.
REQ-035 Start never accepted: m_ready held at 1, TIMEOUT=8 -> r0_ack with r0_err=1 exactly 10 cycles after m_start; busy returns to 0 one cycle later.
REQ-036 Master hang: m_ready goes low and never returns, TIMEOUT=8 -> ack with err=1 after 9 cycles in WAIT_DONE; the next request is then served normally.
REQ-037 Reset mid-transfer: assert reset during WAIT_DONE -> next cycle busy=0, no ack pulse, m_start=0, m_*=0; a request raised after reset is granted to r0 on a tie.
REQ-038 Master not idle: m_ready=0 while in IDLE with r1_req=1 -> no m_start until m_ready=1, then a grant to r1 with m_start exactly 1 cycle after the grant.
